// File: rtl/link_tx_serializer_if.sv
// link_tx_serializer_if: bundles the FWFT FIFO read port and the valid/ready
// link flit channel seen by link_tx_serializer.
//   fifo_empty, fifo_dout : FIFO head status and word (into serializer)
//   fifo_rd_en            : FIFO pop strobe (out of serializer)
//   tx_valid, tx_data,
//   tx_last               : link flit channel (out of serializer)
//   tx_ready              : link backpressure (into serializer)
// master = serializer side, slave = FIFO/PHY side.
interface link_tx_serializer_if #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned LINK_WIDTH = 16
);
    logic                  fifo_empty;
    logic [WIDTH-1:0]      fifo_dout;
    logic                  fifo_rd_en;
    logic                  tx_valid;
    logic [LINK_WIDTH-1:0] tx_data;
    logic                  tx_last;
    logic                  tx_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  tx_ready,
        output fifo_rd_en,
        output tx_valid,
        output tx_data,
        output tx_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output tx_ready,
        input  fifo_rd_en,
        input  tx_valid,
        input  tx_data,
        input  tx_last
    );
endinterface

// File: rtl/link_tx_serializer.sv
// link_tx_serializer: pops WIDTH-bit words from a FWFT FIFO and sends each
// as WIDTH/LINK_WIDTH flits on a valid/ready link, LS flit first, with no
// bubble between back-to-back words.
//   clk, srst  : clock, synchronous active-high reset
//   bus        : FIFO read port + link flit channel (master modport)
//   busy       : high while a word is being transmitted
//   words_sent : count of fully transmitted words, wraps at 2^16
module link_tx_serializer #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned LINK_WIDTH = 16
) (
    input  logic                clk,
    input  logic                srst,
    link_tx_serializer_if.master bus,
    output logic                busy,
    output logic [15:0]         words_sent
);
    localparam int unsigned FLITS = WIDTH / LINK_WIDTH;
    localparam int unsigned CW    = (FLITS > 1) ? $clog2(FLITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      shift_reg, shift_nxt;
    logic [LINK_WIDTH-1:0] data_q, data_nxt;
    logic                  last_q, last_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic [15:0]           words_q, words_nxt;
    logic                  hs, last_hs, pop;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            shift_reg <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            words_q   <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            data_q    <= data_nxt;
            last_q    <= last_nxt;
            cnt_q     <= cnt_nxt;
            words_q   <= words_nxt;
        end
    end

    // Next-state: a pop (from IDLE or on the final handshake) reloads the
    // whole word so the next word follows the last flit with no bubble.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        data_nxt  = data_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        words_nxt = words_q;

        hs      = (state == SEND) && bus.tx_ready;
        last_hs = hs && last_q;
        pop     = !srst && !bus.fifo_empty && ((state == IDLE) || last_hs);

        if (last_hs) begin
            words_nxt = words_q + 16'd1;
        end

        if (pop) begin
            state_nxt = SEND;
            shift_nxt = bus.fifo_dout >> LINK_WIDTH;
            data_nxt  = bus.fifo_dout[LINK_WIDTH-1:0];
            cnt_nxt   = '0;
            last_nxt  = (FLITS == 1);
        end else if (last_hs) begin
            // tx_data intentionally keeps the final flit
            state_nxt = IDLE;
            last_nxt  = 1'b0;
        end else if (hs) begin
            data_nxt  = shift_reg[LINK_WIDTH-1:0];
            shift_nxt = shift_reg >> LINK_WIDTH;
            cnt_nxt   = cnt_q + CW'(1);
            last_nxt  = ((cnt_q + CW'(1)) == CW'(FLITS - 1));
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.tx_valid   = (state == SEND);
    assign bus.tx_data    = data_q;
    assign bus.tx_last    = last_q;
    assign busy           = (state == SEND);
    assign words_sent     = words_q;

endmodule

// File: doc/link_tx_serializer.md
# link_tx_serializer

Drain-side companion to the design's first-word-fall-through FIFOs. It pops WIDTH-bit words from a FWFT FIFO read port (empty/dout/rd_en) and transmits each word as WIDTH/LINK_WIDTH flits over a narrower valid/ready inter-FPGA link, least-significant flit first. It sits between a per-link outbound message FIFO and the link PHY wrapper. Back-to-back words are sent with no bubble.

## Interface

Parameters:
- WIDTH, 64, FIFO word width in bits; must be an integer multiple of LINK_WIDTH.
- LINK_WIDTH, 16, link flit width in bits.
- Derived: FLITS = WIDTH/LINK_WIDTH; CW = max(1, $clog2(FLITS)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- srst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FWFT FIFO empty; fifo_dout is valid when low.
- fifo_dout  in  WIDTH  FWFT FIFO head word.
- fifo_rd_en  out  1  pop strobe, combinational; the FIFO dequeues on the edge where it is high.
- tx_valid  out  1  flit valid, registered.
- tx_data  out  LINK_WIDTH  flit payload, registered.
- tx_last  out  1  high on the final flit of a word, registered.
- tx_ready  in  1  link accepts the flit on the edge where tx_valid && tx_ready.
- busy  out  1  high while in SEND.
- words_sent  out  16  count of fully transmitted words; wraps modulo 2^16.

## Operation

- State machine with two states:
  - IDLE: tx_valid=0.
  - SEND: tx_valid=1.
- Handshake: hs = tx_valid && tx_ready. Final handshake: last_hs = hs && tx_last.
- Pop condition: fifo_rd_en = !srst && !fifo_empty && (state==IDLE || last_hs).
- On a pop edge:
  - shift_reg <= fifo_dout >> LINK_WIDTH
  - tx_data <= fifo_dout[LINK_WIDTH-1:0]
  - flit_cnt <= 0
  - tx_last <= (FLITS==1)
  - state <= SEND
- On a non-final handshake:
  - tx_data <= shift_reg[LINK_WIDTH-1:0]
  - shift_reg <= shift_reg >> LINK_WIDTH
  - flit_cnt <= flit_cnt+1
  - tx_last <= (flit_cnt+1 == FLITS-1)
- On last_hs:
  - words_sent increments.
  - If a pop occurs on the same edge, load the next word as above and stay in SEND.
  - Otherwise go to IDLE, deassert tx_valid and tx_last, and hold tx_data at its last value.
- Stall rule: while tx_valid && !tx_ready, tx_data, tx_last, flit_cnt and shift_reg are held stable. No pop occurs.
- The block never pops while a word is partially sent. Each FIFO word maps to exactly FLITS flits, in order flit 0 (bits [LINK_WIDTH-1:0]) to flit FLITS-1 (MSBs).
- FLITS==1: tx_last is constantly 1 while valid, and tx_data = the full word.
- Reset values: state=IDLE, tx_valid=0, tx_data=0, tx_last=0, busy=0, words_sent=0, flit_cnt=0, shift_reg=0, fifo_rd_en=0.
- srst mid-word: the partial word is abandoned and no further flits of it are sent. The FIFO is not rewound; the upstream side resets the FIFO with the same srst.

## Timing

- Pop-to-flit latency: fifo_empty falls in IDLE at cycle N, so fifo_rd_en is high in cycle N and tx_valid/flit 0 appear in cycle N+1.
- With tx_ready held high, flit k is presented in cycle N+1+k, and tx_last is in cycle N+FLITS.
- A next word available at cycle N+FLITS is popped in that cycle, and its flit 0 appears in N+FLITS+1. Sustained throughput is one flit per cycle.
- words_sent updates on the cycle after last_hs.
- busy equals tx_valid.
- fifo_rd_en depends combinationally on tx_ready, tx_last, tx_valid and fifo_empty. There is no combinational path from fifo_dout to any output.

## Test plan

- Reset: assert srst for 3 cycles with fifo_empty=0 -> fifo_rd_en=0, tx_valid=0, tx_data=0, words_sent=0 throughout.
- Single word, WIDTH=64, LINK_WIDTH=16, tx_ready=1: push 0x4444_3333_2222_1111 -> one pop, then flits 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, tx_last only on 0x4444, then tx_valid=0, words_sent=1.
- Back-to-back: 3 words queued, tx_ready=1 -> 12 consecutive valid cycles, no bubble, pops exactly on the cycles where tx_last handshakes (plus the first), words_sent=3.
- Backpressure: tx_ready low for 5 cycles during flit 2 -> tx_data holds 0x3333 and tx_last=0 for all 5 cycles, no pop. The sequence then resumes unchanged.
- Mid-word reset: srst asserted after flit 1 accepted -> next cycle tx_valid=0 and words_sent=0. A subsequent new word is sent from flit 0.
- FLITS=1 and wrap: WIDTH=LINK_WIDTH=16, send 65537 words -> tx_last=1 on every flit, and words_sent=1 at the end.
